// File: rtl/rst_seq_core.sv
// Reset sequencer: synchronises the PLL reset, then releases the peripheral and core resets in stages.
// It also turns a level-sampled software request into a core-only reset pulse.
module rst_seq_core #(
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int SWRST_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw_rst,
    output logic o_rst_periph,
    output logic o_rst_core,
    output logic o_ready
);

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        PERIPH,
        RUN,
        SWRST
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(STAGE_GAP - 1);
    localparam logic [7:0] SWRST_LAST = 8'(SWRST_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] cnt;
    logic [7:0] next_cnt;
    logic [1:0] rst_sync_q;
    logic       rst_sync;
    logic       rst_periph_d;
    logic       rst_core_d;
    logic       ready_d;

    // Assertion is asynchronous; release only takes effect after two clean edges.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_sync = rst_sync_q[1];

    // State register. Outputs are registered too, so they never glitch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= SYNC;
            cnt          <= '0;
            o_rst_periph <= 1'b1;
            o_rst_core   <= 1'b1;
            o_ready      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state        <= next_state;
            cnt          <= next_cnt;
            o_rst_periph <= rst_periph_d;
            o_rst_core   <= rst_core_d;
            o_ready      <= ready_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case infers a latch.
        next_state = state;
        next_cnt   = cnt;
        case (state)
            SYNC: begin
                if (!rst_sync) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    next_state = PERIPH;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            PERIPH: begin
                if (cnt == GAP_LAST) begin
                    next_state = RUN;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            RUN: begin
                if (i_sw_rst) begin
                    next_state = SWRST;
                    next_cnt   = '0;
                end
            end
            SWRST: begin
                // Saturate at terminal count; stay in reset while the request persists.
                if (cnt == SWRST_LAST) begin
                    if (!i_sw_rst) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end
                end else begin
                    next_cnt = cnt + 8'd1;
                end
            end
            default: begin
                next_state = SYNC;
                next_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that they register together with it.
    always_comb begin
        rst_periph_d = (next_state == SYNC) || (next_state == HOLD);
        rst_core_d   = (next_state != RUN);
        ready_d      = (next_state == RUN);
    end

endmodule

// File: tb/tb_rst_seq_core.sv
// Directed bench for rst_seq_core: a default-parameter instance and a minimum-parameter instance (1/1/1).
// Outputs are packed as {rst_periph, rst_core, ready} and sampled 1ns after each rising edge.
module tb_rst_seq_core;

    logic clk;
    logic rst_a, sw_a, periph_a, core_a, ready_a;
    logic rst_b, sw_b, periph_b, core_b, ready_b;
    int   total = 0;
    int   bad   = 0;

    rst_seq_core dut (
        .i_clk        (clk),
        .i_rst        (rst_a),
        .i_sw_rst     (sw_a),
        .o_rst_periph (periph_a),
        .o_rst_core   (core_a),
        .o_ready      (ready_a)
    );

    rst_seq_core #(
        .HOLD_CYCLES  (1),
        .STAGE_GAP    (1),
        .SWRST_CYCLES (1)
    ) dut_min (
        .i_clk        (clk),
        .i_rst        (rst_b),
        .i_sw_rst     (sw_b),
        .o_rst_periph (periph_b),
        .o_rst_core   (core_b),
        .o_ready      (ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] outs(input bit sel);
        return sel ? {periph_b, core_b, ready_b} : {periph_a, core_a, ready_a};
    endfunction

    task automatic drive_rst(input bit sel, input logic v);
        if (sel) rst_b = v;
        else     rst_a = v;
    endtask

    task automatic drive_sw(input bit sel, input logic v);
        if (sel) sw_b = v;
        else     sw_a = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects i_rst to have just fallen; n counts edges from the first edge with i_rst low.
    task automatic replay(input string tag, input bit sel, input int ph, input int cr,
                          input bit sw_on, input int last);
        logic [2:0] exp;
        check({tag, "_n0"}, outs(sel), 3'b110);
        for (int n = 1; n <= last; n++) begin
            tick();
            if (n < ph)                 exp = 3'b110;
            else if (n < cr)            exp = 3'b010;
            else if (sw_on && n > cr)   exp = 3'b010;
            else                        exp = 3'b001;
            check($sformatf("%s_e%0d", tag, n), outs(sel), exp);
        end
    endtask

    task automatic power_seq(input string tag, input bit sel, input int ph, input int cr,
                             input bit sw_on, input int last);
        @(negedge clk);
        drive_rst(sel, 1'b1);
        #1;
        check({tag, "_async"}, outs(sel), 3'b110);
        repeat (5) tick();
        check({tag, "_held"}, outs(sel), 3'b110);
        @(negedge clk);
        drive_rst(sel, 1'b0);
        replay(tag, sel, ph, cr, sw_on, last);
    endtask

    // Raise the request for hold edges and expect the core in reset for exp_len edges.
    task automatic sw_pulse(input string tag, input bit sel, input int hold, input int exp_len);
        @(negedge clk);
        drive_sw(sel, 1'b1);
        for (int k = 0; k < exp_len + 3; k++) begin
            tick();
            check($sformatf("%s_k%0d", tag, k), outs(sel), (k < exp_len) ? 3'b010 : 3'b001);
            @(negedge clk);
            if (k + 1 == hold) drive_sw(sel, 1'b0);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        sw_a  = 1'b0;
        rst_b = 1'b1;
        sw_b  = 1'b0;

        // Power-on with defaults: periph released after edge 19, core and ready after edge 27.
        power_seq("por", 1'b0, 19, 27, 1'b0, 30);

        // A single-cycle request gives a 4-cycle core pulse; a 10-cycle request gives 10 cycles.
        sw_pulse("sw1", 1'b0, 1, 4);
        sw_pulse("sw10", 1'b0, 10, 10);

        // Half-period reset pulse in PERIPH at cnt=3 (edge 22), then a full replay.
        power_seq("pre_mid", 1'b0, 19, 27, 1'b0, 22);
        #1 rst_a = 1'b1;
        #1 check("mid_async", outs(1'b0), 3'b110);
        #4 rst_a = 1'b0;
        #1 replay("mid_replay", 1'b0, 19, 27, 1'b0, 29);

        // Request held through HOLD/PERIPH is ignored until RUN, then taken on the next edge.
        drive_sw(1'b0, 1'b1);
        power_seq("ign", 1'b0, 19, 27, 1'b1, 30);
        @(negedge clk);
        drive_sw(1'b0, 1'b0);
        repeat (5) tick();
        check("ign_recover", outs(1'b0), 3'b001);

        // Minimum parameters: periph after edge 4, core after edge 5, 1-cycle software pulse.
        power_seq("min", 1'b1, 4, 5, 1'b0, 8);
        sw_pulse("min_sw", 1'b1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_core.md
RST_SEQ_CORE -- requirements
Module: rst_seq_core

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16: cycles held after synchronised reset release, before peripheral reset deasserts (legal 1..255).
REQ-002 The block SHALL have parameter STAGE_GAP, default 8: cycles between peripheral and core reset deassertion (legal 1..255).
REQ-003 The block SHALL have parameter SWRST_CYCLES, default 4: minimum core-reset pulse width for a software reset (legal 1..255).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; it is the PLL-generated core clock.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high; it is driven by the clock generator's locked-derived reset.
REQ-006 The block SHALL have port i_sw_rst, input, 1 bit: synchronous software/debug core-reset request, level-sampled.
REQ-007 The block SHALL have port o_rst_periph, output, 1 bit: active-high reset for the peripheral/interconnect domain.
REQ-008 The block SHALL have port o_rst_core, output, 1 bit: active-high reset for the CPU core.
REQ-009 The block SHALL have port o_ready, output, 1 bit: high only while the core is out of reset in RUN state.

Function
REQ-010 The block SHALL contain a 2-flop reset synchroniser rst_sync: i_rst sets both flops asynchronously; otherwise 0 shifts in, so rst_sync falls on the 2nd rising edge after i_rst deasserts.
REQ-011 The FSM SHALL have states SYNC, HOLD, PERIPH, RUN and SWRST, and an 8-bit counter cnt; all outputs SHALL be registered.
REQ-012 In SYNC the FSM SHALL remain while rst_sync=1; when rst_sync=0 it SHALL go to HOLD with cnt<=0.
REQ-013 In HOLD cnt SHALL increment each cycle; when cnt==HOLD_CYCLES-1 the FSM SHALL go to PERIPH with cnt<=0 and o_rst_periph<=0.
REQ-014 In PERIPH cnt SHALL increment each cycle; when cnt==STAGE_GAP-1 the FSM SHALL go to RUN with o_rst_core<=0 and o_ready<=1.
REQ-015 Resulting latency: o_rst_periph SHALL deassert after rising edge HOLD_CYCLES+3, and o_rst_core after edge HOLD_CYCLES+STAGE_GAP+3, counted from the first edge with i_rst low.
REQ-016 In RUN, i_sw_rst=1 sampled at an edge SHALL move the FSM to SWRST at that edge, with o_rst_core<=1, o_ready<=0 and cnt<=0.
REQ-017 In SWRST cnt SHALL increment up to SWRST_CYCLES-1 and then saturate.
REQ-018 At SWRST terminal count, if i_sw_rst=0 the FSM SHALL return to RUN with o_rst_core<=0 and o_ready<=1; if i_sw_rst=1 the FSM SHALL hold SWRST (core stays in reset while the request persists).
REQ-019 o_rst_periph SHALL NOT be affected by i_sw_rst in any state.
REQ-020 i_sw_rst SHALL be ignored in SYNC, HOLD and PERIPH.
REQ-021 o_ready SHALL equal (state==RUN) at all times.
REQ-022 o_rst_periph=0 SHALL imply the FSM has passed HOLD.
REQ-023 o_rst_core=0 SHALL imply o_rst_periph=0.

Reset
REQ-024 When i_rst is asserted, the block SHALL asynchronously force: state=SYNC, cnt=0, o_rst_periph=1, o_rst_core=1, o_ready=0, rst_sync=11.
REQ-025 An i_rst assertion at any point (mid-HOLD, mid-PERIPH, RUN, SWRST), including a pulse shorter than one clock period, SHALL force all outputs to reset values immediately and restart the full sequence from SYNC.
REQ-026 Reset deassertion SHALL take effect only through rst_sync; no output SHALL change on the same edge that i_rst falls.

Verification
REQ-027 Power-on test: defaults, i_rst high 5 cycles then low -> o_rst_periph falls after edge 19, o_rst_core falls after edge 27, o_ready rises with o_rst_core.
REQ-028 Software-reset test: in RUN, i_sw_rst high for 1 cycle -> o_rst_core high for exactly 4 cycles, o_ready low for the same 4 cycles, o_rst_periph stays 0.
REQ-029 Held-request test: in RUN, i_sw_rst held high for 10 cycles -> o_rst_core high from the sampling edge until the first terminal-count edge with i_sw_rst=0 (10 cycles), with no intermediate deassertion glitch.
REQ-030 Mid-sequence reset test: i_rst pulsed for half a clock period while in PERIPH at cnt=3 -> all outputs reset at once, and the full 19/27-edge sequence replays.
REQ-031 Ignored-request test: i_sw_rst held high throughout HOLD and PERIPH -> timing identical to REQ-027; FSM enters RUN then SWRST on the next edge.
REQ-032 Parameter test: HOLD_CYCLES=1, STAGE_GAP=1, SWRST_CYCLES=1 -> periph release after edge 4, core release after edge 5, software-reset pulse exactly 1 cycle.
